// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/scoreboard unit and its M-op sequencer.
//   seq_state_e     : sequencer state encoding (IDLE/BUSY/DONE)
//   DEF_LAT_LO/HI   : default M-op latencies for funct3[1] = 0 / 1
//   FUNCT3_HI_BIT   : funct3 bit that selects the long latency
package hazard_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_BUSY = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    localparam int DEF_LAT_LO    = 6;
    localparam int DEF_LAT_HI    = 7;
    localparam int FUNCT3_HI_BIT = 1;

    // Counter width able to hold every value up to the longest latency.
    function automatic int seq_cnt_width(input int lat_hi);
        return $clog2(lat_hi + 1);
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle M-extension sequencer: FSM plus cycle counter.
//
// state | meaning
// IDLE  | no M-op in flight; start_i launches one
// BUSY  | counting, cnt runs 1 .. lat-1
// DONE  | result ready; leaves when done_o fires
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : launch an M-op (only honoured in IDLE)
//   lat_sel_i      : 0 = LAT_LO, 1 = LAT_HI
//   wb_busy_i      : writeback port taken (holds DONE when non-blocking)
//   busy_o         : state != IDLE
//   counting_o     : state == BUSY
//   done_o         : one-cycle result/writeback pulse
module mul_sequencer
    import hazard_pkg::*;
#(
    parameter int LAT_LO   = DEF_LAT_LO,
    parameter int LAT_HI   = DEF_LAT_HI,
    parameter int BLOCKING = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic lat_sel_i,
    input  logic wb_busy_i,
    output logic busy_o,
    output logic counting_o,
    output logic done_o
);

    localparam int CW = seq_cnt_width(LAT_HI);
    localparam logic [CW-1:0] LAT_LO_C = CW'(LAT_LO);
    localparam logic [CW-1:0] LAT_HI_C = CW'(LAT_HI);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] lat_q;
    logic          release_ok;

    // A blocking M-op owns the writeback slot because the front end is frozen.
    assign release_ok = (BLOCKING != 0) || !wb_busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            lat_q   <= LAT_LO_C;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        state_q <= SEQ_BUSY;
                        cnt_q   <= ONE_C;
                        lat_q   <= lat_sel_i ? LAT_HI_C : LAT_LO_C;
                    end
                end
                SEQ_BUSY: begin
                    // >= rather than == keeps the counter bounded even for lat = 1
                    if (cnt_q >= lat_q - ONE_C) begin
                        state_q <= SEQ_DONE;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                SEQ_DONE: begin
                    if (release_ok) begin
                        state_q <= SEQ_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= SEQ_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o     = (state_q != SEQ_IDLE);
    assign counting_o = (state_q == SEQ_BUSY);
    assign done_o     = (state_q == SEQ_DONE) && release_ok;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Stall / bubble / flush control for the RV32IM pipeline, with per-register
// write tracking for non-blocking M-ops and an internal M-op sequencer.
//
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   ifid_rs1_i/rs2_i, ifid_use_rs*_i  : ID sources and their use bits
//   ifid_rd_i, ifid_regwrite_i        : ID destination (WAW check)
//   ifid_branch_i, ifid_jalr_i        : ID instruction resolves in ID
//   idex_*_i                          : EX-stage instruction info
//   exmem_memread_i, exmem_rd_i       : MEM-stage load info
//   wb_busy_i                         : writeback port in use
//   resolve_valid_i, predicted_i, taken_i : ID branch resolution
//   pc_write_o, ifid_write_o, idex_write_o : stage enables
//   bubble_ex_o, bubble_mem_o, flush_if_o  : NOP insertion / IF kill
//   mul_busy_o, mul_done_o            : sequencer status / result pulse
//   pending_o                         : scoreboard (bit 0 always 0)
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int RAW      = $clog2(NREGS),
    parameter int LAT_LO   = DEF_LAT_LO,
    parameter int LAT_HI   = DEF_LAT_HI,
    parameter int BLOCKING = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RAW-1:0]   ifid_rs1_i,
    input  logic [RAW-1:0]   ifid_rs2_i,
    input  logic             ifid_use_rs1_i,
    input  logic             ifid_use_rs2_i,
    input  logic [RAW-1:0]   ifid_rd_i,
    input  logic             ifid_regwrite_i,
    input  logic             ifid_branch_i,
    input  logic             ifid_jalr_i,
    input  logic             idex_regwrite_i,
    input  logic             idex_memread_i,
    input  logic             idex_mul_i,
    input  logic [RAW-1:0]   idex_rd_i,
    input  logic [2:0]       idex_funct3_i,
    input  logic             exmem_memread_i,
    input  logic [RAW-1:0]   exmem_rd_i,
    input  logic             wb_busy_i,
    input  logic             resolve_valid_i,
    input  logic             predicted_i,
    input  logic             taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             bubble_ex_o,
    output logic             bubble_mem_o,
    output logic             flush_if_o,
    output logic             mul_busy_o,
    output logic             mul_done_o,
    output logic [NREGS-1:0] pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [RAW-1:0]   mul_rd_q;

    logic seq_busy;
    logic seq_counting;
    logic seq_done;
    logic start;
    logic p1_struct;
    logic p2_branch;
    logic p3_load_use;
    logic p4_scoreboard;
    logic [2:0] funct3_unused;

    // Only the latency-select bit of funct3 matters here.
    assign funct3_unused = idex_funct3_i;

    // A source hits rd when rd is a real register, indices match and the
    // source is actually read.
    function automatic logic src_hit(input logic [RAW-1:0] rd,
                                     input logic [RAW-1:0] rs1,
                                     input logic           use1,
                                     input logic [RAW-1:0] rs2,
                                     input logic           use2);
        return (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    // An M-op can only launch from IDLE, so start and DONE->IDLE never collide.
    assign start = idex_mul_i && !seq_busy;

    mul_sequencer #(
        .LAT_LO   (LAT_LO),
        .LAT_HI   (LAT_HI),
        .BLOCKING (BLOCKING)
    ) u_mul_sequencer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start),
        .lat_sel_i  (idex_funct3_i[FUNCT3_HI_BIT]),
        .wb_busy_i  (wb_busy_i),
        .busy_o     (seq_busy),
        .counting_o (seq_counting),
        .done_o     (seq_done)
    );

    always_comb begin
        // Blocking: freeze from the start cycle through the last BUSY cycle.
        // Non-blocking: only a second M-op arriving while one is in flight stalls.
        if (BLOCKING != 0) begin
            p1_struct = start || seq_counting;
        end else begin
            p1_struct = idex_mul_i && seq_busy;
        end

        p2_branch = (ifid_branch_i || ifid_jalr_i) &&
                    ((idex_regwrite_i && src_hit(idex_rd_i, ifid_rs1_i, ifid_use_rs1_i,
                                                 ifid_rs2_i, ifid_use_rs2_i)) ||
                     (exmem_memread_i && src_hit(exmem_rd_i, ifid_rs1_i, ifid_use_rs1_i,
                                                 ifid_rs2_i, ifid_use_rs2_i)));

        p3_load_use = idex_memread_i &&
                      src_hit(idex_rd_i, ifid_rs1_i, ifid_use_rs1_i,
                              ifid_rs2_i, ifid_use_rs2_i);

        p4_scoreboard = (ifid_use_rs1_i && pending_q[ifid_rs1_i]) ||
                        (ifid_use_rs2_i && pending_q[ifid_rs2_i]) ||
                        (ifid_regwrite_i && pending_q[ifid_rd_i]);
    end

    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        idex_write_o = 1'b1;
        bubble_ex_o  = 1'b0;
        bubble_mem_o = 1'b0;
        flush_if_o   = 1'b0;
        mul_busy_o   = seq_busy;
        mul_done_o   = seq_done;
        pending_o    = pending_q;

        if (p1_struct) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_write_o = 1'b0;
            bubble_mem_o = 1'b1;
        end else if (p2_branch || p3_load_use || p4_scoreboard) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_ex_o  = 1'b1;
        end else begin
            flush_if_o = resolve_valid_i && (predicted_i ^ taken_i);
        end

        // A non-blocking M-op leaves the pipe into the sequencer.
        if ((BLOCKING == 0) && start) begin
            bubble_mem_o = 1'b1;
        end

        if (rst_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_write_o = 1'b1;
            bubble_ex_o  = 1'b0;
            bubble_mem_o = 1'b0;
            flush_if_o   = 1'b0;
            mul_busy_o   = 1'b0;
            mul_done_o   = 1'b0;
            pending_o    = '0;
        end
    end

    // Clear on the writeback pulse takes effect next cycle, so an ID read of
    // that register in the mul_done cycle is still stalled.
    always_comb begin
        pending_d = pending_q;
        if (BLOCKING == 0) begin
            if (seq_done) begin
                pending_d[mul_rd_q] = 1'b0;
            end
            if (start && (idex_rd_i != '0)) begin
                pending_d[idex_rd_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            mul_rd_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (start) begin
                mul_rd_q <= idex_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Drives a blocking (index 0) and a non-blocking (index 1) instance with the
// same stimulus and compares both against a cycle-level reference model that
// tracks each M-op by its age since launch.
module tb_hazard_scoreboard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2, ifid_rd, idex_rd, exmem_rd;
    logic       use1, use2, ifid_regwrite, ifid_branch, ifid_jalr;
    logic       idex_regwrite, idex_memread, idex_mul, exmem_memread;
    logic [2:0] funct3;
    logic       wb_busy, resolve_valid, predicted, taken;

    logic [1:0]  pc_w, ifid_w, idex_w, bex, bmem, flush, mbusy, mdone;
    logic [31:0] pend [2];

    hazard_scoreboard_unit #(.NREGS(32), .LAT_LO(6), .LAT_HI(7), .BLOCKING(1)) u_blk (
        .clk_i(clk), .rst_i(rst),
        .ifid_rs1_i(ifid_rs1), .ifid_rs2_i(ifid_rs2),
        .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
        .ifid_rd_i(ifid_rd), .ifid_regwrite_i(ifid_regwrite),
        .ifid_branch_i(ifid_branch), .ifid_jalr_i(ifid_jalr),
        .idex_regwrite_i(idex_regwrite), .idex_memread_i(idex_memread),
        .idex_mul_i(idex_mul), .idex_rd_i(idex_rd), .idex_funct3_i(funct3),
        .exmem_memread_i(exmem_memread), .exmem_rd_i(exmem_rd),
        .wb_busy_i(wb_busy), .resolve_valid_i(resolve_valid),
        .predicted_i(predicted), .taken_i(taken),
        .pc_write_o(pc_w[0]), .ifid_write_o(ifid_w[0]), .idex_write_o(idex_w[0]),
        .bubble_ex_o(bex[0]), .bubble_mem_o(bmem[0]), .flush_if_o(flush[0]),
        .mul_busy_o(mbusy[0]), .mul_done_o(mdone[0]), .pending_o(pend[0])
    );

    hazard_scoreboard_unit #(.NREGS(32), .LAT_LO(6), .LAT_HI(7), .BLOCKING(0)) u_nb (
        .clk_i(clk), .rst_i(rst),
        .ifid_rs1_i(ifid_rs1), .ifid_rs2_i(ifid_rs2),
        .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
        .ifid_rd_i(ifid_rd), .ifid_regwrite_i(ifid_regwrite),
        .ifid_branch_i(ifid_branch), .ifid_jalr_i(ifid_jalr),
        .idex_regwrite_i(idex_regwrite), .idex_memread_i(idex_memread),
        .idex_mul_i(idex_mul), .idex_rd_i(idex_rd), .idex_funct3_i(funct3),
        .exmem_memread_i(exmem_memread), .exmem_rd_i(exmem_rd),
        .wb_busy_i(wb_busy), .resolve_valid_i(resolve_valid),
        .predicted_i(predicted), .taken_i(taken),
        .pc_write_o(pc_w[1]), .ifid_write_o(ifid_w[1]), .idex_write_o(idex_w[1]),
        .bubble_ex_o(bex[1]), .bubble_mem_o(bmem[1]), .flush_if_o(flush[1]),
        .mul_busy_o(mbusy[1]), .mul_done_o(mdone[1]), .pending_o(pend[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an in-flight M-op is described by its age in cycles
    // since launch; it is counting while age < lat and finished afterwards.
    bit          m_run [2];
    int          m_age [2];
    int          m_lat [2];
    int          m_rd  [2];
    logic [31:0] m_pend[2];

    logic [7:0]  snap [2];
    logic [31:0] psnap[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] rd);
        return (rd != 5'd0) && ((use1 && ifid_rs1 == rd) || (use2 && ifid_rs2 == rd));
    endfunction

    function automatic logic [7:0] obs(input int b);
        return {pc_w[b], ifid_w[b], idex_w[b], bex[b], bmem[b], flush[b], mbusy[b], mdone[b]};
    endfunction

    // Bit order: pc, ifid, idex, bubble_ex, bubble_mem, flush, busy, done
    function automatic logic [7:0] exp_out(input int b);
        bit blk      = (b == 0);
        bit launch   = !m_run[b] && idex_mul;
        bit counting = m_run[b] && (m_age[b] < m_lat[b]);
        bit finished = m_run[b] && (m_age[b] >= m_lat[b]);
        bit p1 = blk ? (launch || counting) : (idex_mul && m_run[b]);
        bit p2 = (ifid_branch || ifid_jalr) &&
                 ((idex_regwrite && hit(idex_rd)) || (exmem_memread && hit(exmem_rd)));
        bit p3 = idex_memread && hit(idex_rd);
        bit p4 = (use1 && m_pend[b][ifid_rs1]) || (use2 && m_pend[b][ifid_rs2]) ||
                 (ifid_regwrite && m_pend[b][ifid_rd]);
        logic [7:0] e = 8'b1110_0000;
        if (rst) return 8'b1110_0000;
        if (p1) begin
            e[7] = 1'b0; e[6] = 1'b0; e[5] = 1'b0; e[3] = 1'b1;
        end else if (p2 || p3 || p4) begin
            e[7] = 1'b0; e[6] = 1'b0; e[4] = 1'b1;
        end else begin
            e[2] = resolve_valid && (predicted != taken);
        end
        if (!blk && launch) e[3] = 1'b1;
        e[1] = m_run[b];
        e[0] = finished && (blk || !wb_busy);
        return e;
    endfunction

    function automatic logic [31:0] exp_pend(input int b);
        return rst ? 32'd0 : m_pend[b];
    endfunction

    task automatic model_update(input int b);
        if (rst) begin
            m_run[b]  = 1'b0;
            m_age[b]  = 0;
            m_pend[b] = '0;
        end else if (!m_run[b] && idex_mul) begin
            m_run[b] = 1'b1;
            m_age[b] = 1;
            m_lat[b] = funct3[1] ? 7 : 6;
            m_rd[b]  = int'(idex_rd);
            if (b == 1 && idex_rd != 5'd0) m_pend[b][idex_rd] = 1'b1;
        end else if (m_run[b] && m_age[b] < m_lat[b]) begin
            m_age[b]++;
        end else if (m_run[b] && (b == 0 || !wb_busy)) begin
            m_run[b] = 1'b0;
            if (b == 1) m_pend[b][m_rd[b]] = 1'b0;
        end
    endtask

    // Inputs are set by the caller; outputs are sampled 2 time units after
    // that, the model advances at the clock edge.
    task automatic cycle();
        #2;
        for (int b = 0; b < 2; b++) begin
            snap[b]  = obs(b);
            psnap[b] = pend[b];
            check(b == 0 ? "blk_out" : "nb_out", 64'(snap[b]), 64'(exp_out(b)));
            check(b == 0 ? "blk_pend" : "nb_pend", 64'(psnap[b]), 64'(exp_pend(b)));
        end
        @(posedge clk);
        for (int b = 0; b < 2; b++) model_update(b);
        #1;
    endtask

    task automatic clr();
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_rd = '0; idex_rd = '0; exmem_rd = '0;
        use1 = 0; use2 = 0; ifid_regwrite = 0; ifid_branch = 0; ifid_jalr = 0;
        idex_regwrite = 0; idex_memread = 0; idex_mul = 0; exmem_memread = 0;
        funct3 = '0; wb_busy = 0; resolve_valid = 0; predicted = 0; taken = 0;
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
    endfunction

    task automatic run_block(input logic [2:0] f, input int exp_lat);
        int stalls = 0;
        int stalls_at_done = -1;
        bit done_seen = 0;
        clr();
        idex_mul = 1'b1;
        funct3   = f;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            cycle();
            if (!snap[0][5]) stalls++;
            if (snap[0][0]) begin
                done_seen = 1;
                stalls_at_done = stalls;
                check("blk_release", 64'(snap[0][5]), 64'd1);
            end
        end
        check("blk_done_seen", 64'(done_seen), 64'd1);
        check("blk_stalls", 64'(stalls_at_done), 64'(exp_lat));
        clr();
        repeat (3) cycle();
    endtask

    initial begin
        int cnt;
        int done_age;
        for (int b = 0; b < 2; b++) begin
            m_run[b] = 0; m_age[b] = 0; m_lat[b] = 6; m_rd[b] = 0; m_pend[b] = '0;
        end
        clr();
        rst = 1'b1;
        cycle();
        check("rst_vec_blk", 64'(snap[0]), 64'h0E0);
        check("rst_vec_nb", 64'(snap[1]), 64'h0E0);
        cycle();
        rst = 1'b0;
        cycle();

        // load-use, with and without the use bit
        idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; use1 = 1;
        cycle();
        check("lu_stall", 64'({snap[1][7], snap[1][4]}), 64'b01);
        use1 = 0;
        cycle();
        check("lu_nouse", 64'({snap[1][7], snap[1][4]}), 64'b10);

        // branch on a load: P3 then P2 then release
        clr();
        ifid_branch = 1; ifid_rs2 = 7; use2 = 1; idex_memread = 1; idex_rd = 7;
        cnt = 0;
        cycle(); cnt += int'(snap[1][4]);
        idex_memread = 0; exmem_memread = 1; exmem_rd = 7;
        cycle(); cnt += int'(snap[1][4]);
        exmem_memread = 0;
        cycle();
        check("bol_stalls", 64'(cnt), 64'd2);
        check("bol_release", 64'({snap[1][7], snap[1][4]}), 64'b10);

        // mispredict alone, then masked by a load-use hazard
        clr();
        resolve_valid = 1; predicted = 1; taken = 0;
        cycle();
        check("mp_flush", 64'(snap[1][2]), 64'd1);
        idex_memread = 1; idex_rd = 4; ifid_rs1 = 4; use1 = 1;
        cycle();
        check("mp_masked", 64'({snap[1][2], snap[1][4]}), 64'b01);
        clr();
        cycle();

        // blocking latencies
        run_block(3'b000, 6);
        run_block(3'b011, 7);

        // non-blocking M-op to x9
        clr();
        idex_mul = 1; idex_rd = 9;
        cycle();
        check("nb_start", 64'({snap[1][7], snap[1][5], snap[1][3]}), 64'b111);
        clr();
        ifid_rs1 = 3; use1 = 1;
        cycle();
        check("nb_indep", 64'({snap[1][7], snap[1][4]}), 64'b10);
        check("nb_pend9", 64'(psnap[1][9]), 64'd1);
        ifid_rs1 = 9;
        cnt = 0; done_age = 0;
        for (int a = 2; a <= 20 && done_age == 0; a++) begin
            wb_busy  = (a == 6 || a == 7);
            idex_mul = (a == 4);
            idex_rd  = (a == 4) ? 5'd10 : 5'd0;
            cycle();
            if (!snap[1][7]) cnt++;
            if (snap[1][0]) done_age = a;
            if (a == 4) check("nb_second_mop", 64'({snap[1][5], snap[1][3]}), 64'b01);
        end
        check("nb_done_age", 64'(done_age), 64'd8);
        check("nb_rs_stalls", 64'(cnt), 64'd7);
        wb_busy = 0; idex_mul = 0;
        cycle();
        check("nb_release", 64'({snap[1][7], psnap[1][9]}), 64'b10);
        clr();
        repeat (3) cycle();

        // reset in BUSY at cnt = 3, then a fresh launch right after
        idex_mul = 1; idex_rd = 12;
        cycle();
        clr();
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        check("rst_mid_blk", 64'(snap[0]), 64'h0E0);
        check("rst_mid_nb", 64'({snap[1], psnap[1]}), 64'h0E0_0000_0000);
        idex_mul = 1; idex_rd = 13;
        cycle();
        clr();
        cycle();
        check("post_rst_start", 64'({snap[0][1], snap[1][1], psnap[1][13]}), 64'b111);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(99) == 0);
            ifid_rs1      = rreg(); ifid_rs2 = rreg(); ifid_rd = rreg();
            idex_rd       = rreg(); exmem_rd = rreg();
            use1          = 1'($urandom_range(1)); use2 = 1'($urandom_range(1));
            ifid_regwrite = 1'($urandom_range(1));
            ifid_branch   = ($urandom_range(3) == 0);
            ifid_jalr     = ($urandom_range(7) == 0);
            idex_regwrite = 1'($urandom_range(1));
            idex_memread  = ($urandom_range(3) == 0);
            idex_mul      = ($urandom_range(11) == 0);
            funct3        = 3'($urandom_range(7));
            exmem_memread = ($urandom_range(3) == 0);
            wb_busy       = ($urandom_range(9) < 3);
            resolve_valid = 1'($urandom_range(1));
            predicted     = 1'($urandom_range(1));
            taken         = 1'($urandom_range(1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor of the pipeline hazard detection logic. It sits beside the ID stage and produces all stall, bubble and flush controls for the RV32IM pipeline. It adds per-register write tracking with use-bit qualification, plus an internal multi-cycle M-extension sequencer with configurable latencies. The M-op is either blocking (freezes the front end) or non-blocking (scoreboarded, with its writeback arbitrated against `wb_busy`).

## Interface
- `NREGS`, 32: architectural registers; `RAW = $clog2(NREGS)`
- `LAT_LO`, 6: M-op latency in cycles when `idex_funct3[1]==0`
- `LAT_HI`, 7: M-op latency in cycles when `idex_funct3[1]==1`
- `BLOCKING`, 1: 1 = freeze pipeline during M-op; 0 = scoreboarded
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `ifid_rs1`, `ifid_rs2` in RAW: ID source registers; `ifid_use_rs1`, `ifid_use_rs2` in 1: the sources are actually read
- `ifid_rd` in RAW, `ifid_regwrite` in 1: ID destination, used for WAW checks
- `ifid_branch`, `ifid_jalr` in 1: ID instruction resolves in ID
- `idex_regwrite`, `idex_memread`, `idex_mul` in 1; `idex_rd` in RAW; `idex_funct3` in 3
- `exmem_memread` in 1; `exmem_rd` in RAW
- `wb_busy` in 1: pipeline writeback port is in use this cycle
- `resolve_valid`, `predicted`, `taken` in 1: ID branch resolution
- `pc_write`, `ifid_write`, `idex_write` out 1: stage enables
- `bubble_ex` out 1: insert NOP into ID/EX; `bubble_mem` out 1: insert NOP into EX/MEM
- `flush_if` out 1: kill IF/ID contents
- `mul_busy` out 1; `mul_done` out 1: one-cycle M result valid/writeback pulse
- `pending` out NREGS: scoreboard bits (bit 0 always 0)

## Operation
- A register match requires rd != 0, equal index, and the matching use bit.
- Priority, highest first:
  - P1 M-op structural stall.
  - P2 branch/jalr dependency: `idex_regwrite` rd match, or `exmem_memread` rd match.
  - P3 load-use: `idex_memread` rd match.
  - P4 scoreboard: `pending[rs]` set for a used source, or `ifid_regwrite && pending[ifid_rd]` (WAW).
  - P5 flush.
- P1 response: `pc_write = ifid_write = idex_write = 0`, `bubble_mem = 1`.
- P2–P4 response: `pc_write = ifid_write = 0`, `bubble_ex = 1`.
- P5: `flush_if = resolve_valid & (predicted ^ taken)`, asserted only when P1–P4 are all inactive.
- Sequencer FSM states:
  - IDLE → BUSY on start (`idex_mul` in IDLE). `cnt` loads 1 and `lat` latches LAT_LO or LAT_HI.
  - BUSY: `cnt` increments. When `cnt == lat-1` → DONE.
  - DONE: `mul_done = 1` when `BLOCKING` or `!wb_busy`, then → IDLE. Otherwise stays in DONE.
- BLOCKING=1: P1 is active in the start cycle and throughout BUSY, giving exactly `lat` stall cycles. In DONE the stall releases, `mul_done` fires, and the M-op advances.
- BLOCKING=0:
  - Start cycle: `pending[idex_rd]` is set and `bubble_mem = 1` (the M-op leaves the pipe). There is no front-end stall.
  - P1 is active only when `idex_mul` is present while the FSM is not IDLE.
  - `pending[rd]` clears in the `mul_done` cycle. A same-cycle ID read of that register is still stalled that cycle.
- `mul_busy = (state != IDLE)`.

## Timing
- Every stall/bubble/flush output is combinational from current inputs and registered state. There is zero-cycle latency from hazard to stall.
- Reset values, and forced values while `rst` is high: state IDLE, `cnt = 0`, `pending = 0`. `pc_write = ifid_write = idex_write = 1`; all other outputs 0.
- Reset mid-M-op aborts it with no `mul_done` and clears the scoreboard. A new M-op on the first post-reset cycle starts normally.
- `cnt` width is `$clog2(LAT_HI+1)`. It never wraps; it is bounded by `lat-1`.
- A start and a DONE→IDLE transition never occur in the same cycle: start requires IDLE.
- `wb_busy` held N cycles in DONE delays `mul_done` by N cycles.

## Structure
- `hazard_pkg` holds the sequencer state enum (IDLE/BUSY/DONE), the default `LAT_LO`/`LAT_HI`, and the `FUNCT3_HI_BIT = 1` constant.
- One sub-module, `mul_sequencer`: the FSM plus counter, exposing `start`, `lat_sel`, `wb_busy`, `busy`, `done`. The priority logic and scoreboard stay in the top.

## Test plan
- Load-use: `idex_memread = 1`, `idex_rd = 5`, `ifid_rs1 = 5` with use → one cycle of `pc_write = 0`, `bubble_ex = 1`. With `ifid_use_rs1 = 0` → no stall.
- Branch on load: `idex_memread` rd=7 while branch `rs2 = 7` → stall (P3). Next cycle `exmem_memread` rd=7 → stall (P2). Third cycle → release, 2 stalls total.
- Blocking M-op, funct3=000 → 6 cycles with `idex_write = 0`, `bubble_mem = 1`, then `mul_done` in cycle 6. funct3=011 → 7 cycles.
- Non-blocking: M-op rd=9. An independent add proceeds. A later `ifid_rs1 = 9` stalls until `mul_done`. `wb_busy` high for 2 cycles in DONE delays `mul_done` by 2. A second M-op during BUSY → P1 stall.
- Mispredict: `resolve_valid = 1`, `predicted = 1`, `taken = 0` → `flush_if = 1` the same cycle. The same input with a concurrent load-use hazard → `flush_if = 0`, `bubble_ex = 1`.
- `rst` in BUSY at cnt=3 → next cycle all outputs at reset values, `pending = 0`, no `mul_done`.
